hazard_fwd_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage CPU.
- Tracks destination-register state for the ID/EX, EX/MEM and MEM/WB stages in its own shadow registers.
- Drives the forward_aluin1/forward_aluin2 selects consumed by the execute stage, the load-use stall, and the taken-branch flush.
- Sits beside the pipeline registers and takes decoded register fields from ID and branch resolution from EX.

---
 rtl/hazard_fwd_unit_pkg.sv | 48 ++++
 rtl/hazard_fwd_unit_sat_counter.sv | 39 +++
 rtl/hazard_fwd_unit.sv | 97 +++++++++
 tb/tb_hazard_fwd_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// ============================================================================
// hazard_fwd_unit_pkg : shared forward-select encodings and stage-record type
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_fwd_unit_pkg;

  localparam int RA_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            uses_rs;
    logic            uses_rt;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // r0 is hard-wired zero, so a record aimed at it never produces a value.
  function automatic logic is_writer(input stage_rec_t r);
    return r.valid & r.regwrite & (r.rd != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic            use_src,
                                         input logic [RA_W-1:0] src,
                                         input stage_rec_t      exmem,
                                         input stage_rec_t      memwb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (is_writer(exmem) && (exmem.rd == src))      sel = FWD_MEM;
      else if (is_writer(memwb) && (memwb.rd == src)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (inc_i && (count_q != '1))
      count_d = count_q + C_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : forwarding selects, load-use stall and branch flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW = RA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [1:0]        forward_aluin1,
  output logic [1:0]        forward_aluin2,
  output logic              stall,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  stage_rec_t idex_q, exmem_q, memwb_q;
  stage_rec_t idex_d;
  logic       load_use_w;
  logic       unused_w;

  assign flush_ifid = ex_branch_taken;

  // A taken branch discards the ID instruction, so it cannot also stall.
  assign load_use_w = idex_q.valid & idex_q.memread & idex_q.regwrite &
                      (idex_q.rd != '0) & id_valid &
                      ((id_uses_rs & (id_rs == idex_q.rd)) |
                       (id_uses_rt & (id_rt == idex_q.rd)));
  assign stall = load_use_w & ~ex_branch_taken;

  assign forward_aluin1 = fwd_sel(idex_q.valid & idex_q.uses_rs, idex_q.rs, exmem_q, memwb_q);
  assign forward_aluin2 = fwd_sel(idex_q.valid & idex_q.uses_rt, idex_q.rt, exmem_q, memwb_q);

  always_comb begin
    idex_d = BUBBLE;
    if (id_valid && !stall && !flush_ifid) begin
      idex_d.valid    = 1'b1;
      idex_d.rd       = id_rd;
      idex_d.regwrite = id_regwrite;
      idex_d.memread  = id_memread;
      idex_d.rs       = id_rs;
      idex_d.rt       = id_rt;
      idex_d.uses_rs  = id_uses_rs;
      idex_d.uses_rt  = id_uses_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= BUBBLE;
      exmem_q <= BUBBLE;
      memwb_q <= BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  // Source-operand and load fields are only consulted while in ID/EX.
  assign unused_w = ^{exmem_q.rs, exmem_q.rt, exmem_q.uses_rs, exmem_q.uses_rt, exmem_q.memread,
                      memwb_q.rs, memwb_q.rt, memwb_q.uses_rs, memwb_q.uses_rt, memwb_q.memread};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall),
    .clear_i (1'b0),
    .count_o (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_ifid),
    .clear_i (1'b0),
    .count_o (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// tb_hazard_fwd_unit : scoreboard bench, directed hazard scenarios + random
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        ex_branch_taken;
  logic [1:0]  forward_aluin1, forward_aluin2;
  logic        stall, flush_ifid;
  logic [15:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .forward_aluin1  (forward_aluin1),
    .forward_aluin2  (forward_aluin2),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  typedef struct {
    logic       v;
    logic [3:0] rd, rs, rt;
    logic       urs, urt, rw, mr;
  } ins_t;

  typedef struct {
    logic [1:0]  f1, f2;
    logic        st, fl;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: instructions that entered EX, newest first (0=EX, 1=MEM, 2=WB).
  ins_t hist[3];
  int   scnt, fcnt;

  function automatic ins_t nop();
    ins_t n;
    n = '{v: 1'b0, rd: 4'd0, rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, rw: 1'b0, mr: 1'b0};
    return n;
  endfunction

  function automatic ins_t mk(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                              input logic urs, input logic urt, input logic rw, input logic mr);
    ins_t n;
    n = '{v: 1'b1, rd: rd, rs: rs, rt: rt, urs: urs, urt: urt, rw: rw, mr: mr};
    return n;
  endfunction

  // Youngest older instruction producing src wins; distance 1 = EX/MEM, 2 = MEM/WB.
  function automatic logic [1:0] ref_fwd(input logic use_src, input logic [3:0] src);
    if (!hist[0].v || !use_src) return 2'b00;
    for (int d = 1; d <= 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd != 4'd0 && hist[d].rd == src)
        return (d == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input ins_t i, input logic br, input logic r, input bit chk, output logic st);
    exp_t e;
    id_valid = i.v;  id_rd = i.rd;  id_rs = i.rs;  id_rt = i.rt;
    id_uses_rs = i.urs;  id_uses_rt = i.urt;  id_regwrite = i.rw;  id_memread = i.mr;
    ex_branch_taken = br;
    rst = r;
    st = hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 4'd0 && i.v && !br &&
         ((i.urs && i.rs == hist[0].rd) || (i.urt && i.rt == hist[0].rd));
    e.f1 = ref_fwd(hist[0].urs, hist[0].rs);
    e.f2 = ref_fwd(hist[0].urt, hist[0].rt);
    e.st = st;
    e.fl = br;
    e.sc = scnt[15:0];
    e.fc = fcnt[15:0];
    if (chk) sbq.push_back(e);
    @(posedge clk);
    if (r) begin
      hist[0] = nop(); hist[1] = nop(); hist[2] = nop();
      scnt = 0; fcnt = 0;
    end else begin
      if (st && scnt < 65535) scnt++;
      if (br && fcnt < 65535) fcnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (st || br || !i.v) ? nop() : i;
    end
    #1;
  endtask

  // Issue one instruction, holding it in ID while the hazard unit stalls.
  task automatic issue(input ins_t i, input logic br);
    logic st;
    int   guard;
    guard = 0;
    step(i, br, 1'b0, 1'b1, st);
    while (st && guard < 4) begin
      step(i, 1'b0, 1'b0, 1'b1, st);
      guard++;
    end
  endtask

  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++) issue(nop(), 1'b0);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        cmp("forward_aluin1", int'(forward_aluin1), int'(e.f1));
        cmp("forward_aluin2", int'(forward_aluin2), int'(e.f2));
        cmp("stall",          int'(stall),          int'(e.st));
        cmp("flush_ifid",     int'(flush_ifid),     int'(e.fl));
        cmp("stall_count",    int'(stall_count),    int'(e.sc));
        cmp("flush_count",    int'(flush_count),    int'(e.fc));
      end
    end
  end

  initial begin : driver
    logic st;
    logic br, r;
    ins_t cur;
    hist[0] = nop(); hist[1] = nop(); hist[2] = nop();
    scnt = 0; fcnt = 0;
    cur = nop();
    st = 1'b0;
    step(nop(), 1'b0, 1'b1, 1'b0, st);
    step(nop(), 1'b0, 1'b1, 1'b0, st);
    step(nop(), 1'b0, 1'b1, 1'b1, st);

    // Back-to-back ALU dependency
    issue(mk(4'd3, 4'd1, 4'd2, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd4, 4'd3, 4'd5, 1, 1, 1, 0), 1'b0);
    bubbles(3);
    // Distance-2 dependency, then double producer
    issue(mk(4'd3, 4'd1, 4'd2, 1, 1, 1, 0), 1'b0);
    issue(nop(), 1'b0);
    issue(mk(4'd6, 4'd7, 4'd3, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd3, 4'd1, 4'd2, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd3, 4'd4, 4'd2, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd6, 4'd3, 4'd3, 1, 1, 1, 0), 1'b0);
    bubbles(3);
    // Load-use
    issue(mk(4'd2, 4'd1, 4'd0, 1, 0, 1, 1), 1'b0);
    issue(mk(4'd5, 4'd2, 4'd2, 1, 1, 1, 0), 1'b0);
    bubbles(3);
    // r0 suppression
    issue(mk(4'd0, 4'd1, 4'd1, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd4, 4'd0, 4'd0, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd0, 4'd1, 4'd0, 1, 0, 1, 1), 1'b0);
    issue(mk(4'd4, 4'd0, 4'd0, 1, 1, 1, 0), 1'b0);
    bubbles(3);
    // Taken branch during load-use
    issue(mk(4'd2, 4'd1, 4'd0, 1, 0, 1, 1), 1'b0);
    issue(mk(4'd5, 4'd2, 4'd2, 1, 1, 1, 0), 1'b1);
    bubbles(3);
    // Reset mid-stream, then a dependent instruction
    issue(mk(4'd3, 4'd1, 4'd2, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd4, 4'd1, 4'd0, 1, 0, 1, 1), 1'b0);
    step(mk(4'd6, 4'd3, 4'd4, 1, 1, 1, 0), 1'b0, 1'b1, 1'b1, st);
    issue(mk(4'd6, 4'd3, 4'd4, 1, 1, 1, 0), 1'b0);
    issue(mk(4'd7, 4'd6, 4'd3, 1, 1, 1, 0), 1'b0);
    bubbles(3);

    // Random stream over a small register window to provoke frequent hazards
    st = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!st) begin
        cur.v   = ($urandom_range(7, 0) != 0);
        cur.rd  = 4'($urandom_range(7, 0));
        cur.rs  = 4'($urandom_range(7, 0));
        cur.rt  = 4'($urandom_range(7, 0));
        cur.urs = 1'($urandom_range(1, 0));
        cur.urt = 1'($urandom_range(1, 0));
        cur.mr  = ($urandom_range(3, 0) == 0);
        cur.rw  = cur.mr | ($urandom_range(3, 0) != 0);
      end
      br = ($urandom_range(7, 0) == 0);
      r  = ($urandom_range(199, 0) == 0);
      step(cur, br, r, 1'b1, st);
      if (r) st = 1'b0;
    end

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
